// File: rtl/prirv32_lsu.sv
// rtl/prirv32_lsu.sv - RV32I load/store unit with single-outstanding byte-lane data bus
//
// Purpose:
//   Takes one load/store per handshake from execute and checks alignment and
//   funct3. Legal operations are issued on a request/acknowledge bus with byte
//   strobes. One response pulse goes to writeback, carrying the extended load
//   data or an exception code.
//
// Ports:
//   clk_i, rst_i         clock; asynchronous active-high reset
//   lsu_valid_i/ready_o  operation handshake (ready only while idle)
//   lsu_we_i, funct3_i   store/load select and RV32I width/sign encoding
//   lsu_addr_i, wdata_i  effective byte address and store data
//   lsu_rd_i             destination register for loads
//   mem_req_o .. wdata_o data bus request (held stable until ack)
//   mem_ack_i, err_i     bus completion and error (error qualified by ack)
//   mem_rdata_i          read word, valid with ack
//   rsp_*                one-cycle response; fields hold until the next response
//                        exc: 00 none, 01 misaligned/illegal, 10 bus error, 11 timeout

module prirv32_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        lsu_valid_i,
  output logic        lsu_ready_o,
  input  logic        lsu_we_i,
  input  logic [2:0]  lsu_funct3_i,
  input  logic [31:0] lsu_addr_i,
  input  logic [31:0] lsu_wdata_i,
  input  logic [4:0]  lsu_rd_i,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [3:0]  mem_wstrb_o,
  output logic [31:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic        mem_err_i,
  input  logic [31:0] mem_rdata_i,
  output logic        rsp_valid_o,
  output logic        rsp_wen_o,
  output logic [4:0]  rsp_rd_o,
  output logic [31:0] rsp_data_o,
  output logic [1:0]  rsp_exc_o,
  output logic [31:0] rsp_badaddr_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUS  = 2'd1,
    S_RESP = 2'd2
  } state_t;

  localparam logic [31:0] TIMEOUT_LIMIT = 32'(TIMEOUT_CYCLES);

  state_t      state_q, state_d;
  logic [31:0] cnt_q;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q;
  logic [4:0]  rd_q;

  logic        misaligned, illegal, op_bad;
  logic [31:0] st_wdata;
  logic [3:0]  st_wstrb;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;
  logic [31:0] cnt_inc;
  logic        timeout_hit;

  // Decode of the operation presented by execute.
  always_comb begin
    misaligned = ((lsu_funct3_i[1:0] == 2'b01) && lsu_addr_i[0]) ||
                 ((lsu_funct3_i[1:0] == 2'b10) && (lsu_addr_i[1:0] != 2'b00));
    if (lsu_we_i)
      illegal = lsu_funct3_i[2] || (lsu_funct3_i[1:0] == 2'b11);
    else
      illegal = (lsu_funct3_i == 3'b011) || (lsu_funct3_i[2:1] == 2'b11);
    op_bad = misaligned || illegal;
  end

  // Store data is replicated across lanes so the bus slave only looks at strobes.
  always_comb begin
    st_wdata = lsu_wdata_i;
    st_wstrb = 4'b1111;
    case (lsu_funct3_i[1:0])
      2'b00: begin
        st_wdata = {4{lsu_wdata_i[7:0]}};
        st_wstrb = 4'b0001 << lsu_addr_i[1:0];
      end
      2'b01: begin
        st_wdata = {2{lsu_wdata_i[15:0]}};
        st_wstrb = lsu_addr_i[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        st_wdata = lsu_wdata_i;
        st_wstrb = 4'b1111;
      end
    endcase
    if (!lsu_we_i)
      st_wstrb = 4'b0000;
  end

  // Load lane extraction from the returning bus word.
  always_comb begin
    case (addr_q[1:0])
      2'b00:   ld_byte = mem_rdata_i[7:0];
      2'b01:   ld_byte = mem_rdata_i[15:8];
      2'b10:   ld_byte = mem_rdata_i[23:16];
      default: ld_byte = mem_rdata_i[31:24];
    endcase
    ld_half = addr_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    case (funct3_q)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_data = {24'd0, ld_byte};
      3'b101:  ld_data = {16'd0, ld_half};
      default: ld_data = mem_rdata_i;
    endcase
  end

  // Timeout fires on the edge where the BUS cycle count would reach the limit.
  assign cnt_inc     = cnt_q + 32'd1;
  assign timeout_hit = (TIMEOUT_LIMIT != 32'd0) && (cnt_inc == TIMEOUT_LIMIT);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      state_q <= S_IDLE;
    else
      state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    lsu_ready_o = 1'b0;
    mem_req_o   = 1'b0;
    rsp_valid_o = 1'b0;
    case (state_q)
      S_IDLE: begin
        lsu_ready_o = !rst_i;
        if (lsu_valid_i)
          state_d = op_bad ? S_RESP : S_BUS;
      end
      S_BUS: begin
        mem_req_o = 1'b1;
        if (mem_ack_i || timeout_hit)
          state_d = S_RESP;
      end
      S_RESP: begin
        rsp_valid_o = 1'b1;
        state_d     = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q         <= 32'd0;
      we_q          <= 1'b0;
      funct3_q      <= 3'd0;
      addr_q        <= 32'd0;
      rd_q          <= 5'd0;
      mem_we_o      <= 1'b0;
      mem_addr_o    <= 32'd0;
      mem_wstrb_o   <= 4'd0;
      mem_wdata_o   <= 32'd0;
      rsp_wen_o     <= 1'b0;
      rsp_rd_o      <= 5'd0;
      rsp_data_o    <= 32'd0;
      rsp_exc_o     <= 2'b00;
      rsp_badaddr_o <= 32'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          cnt_q <= 32'd0;
          if (lsu_valid_i) begin
            we_q        <= lsu_we_i;
            funct3_q    <= lsu_funct3_i;
            addr_q      <= lsu_addr_i;
            rd_q        <= lsu_rd_i;
            mem_we_o    <= lsu_we_i;
            mem_addr_o  <= {lsu_addr_i[31:2], 2'b00};
            mem_wstrb_o <= st_wstrb;
            mem_wdata_o <= st_wdata;
            if (op_bad) begin
              rsp_wen_o     <= 1'b0;
              rsp_rd_o      <= lsu_rd_i;
              rsp_data_o    <= 32'd0;
              rsp_exc_o     <= 2'b01;
              rsp_badaddr_o <= lsu_addr_i;
            end
          end
        end
        S_BUS: begin
          cnt_q <= cnt_inc;
          if (mem_ack_i) begin
            rsp_rd_o <= rd_q;
            if (mem_err_i) begin
              rsp_wen_o     <= 1'b0;
              rsp_data_o    <= 32'd0;
              rsp_exc_o     <= 2'b10;
              rsp_badaddr_o <= addr_q;
            end else begin
              rsp_wen_o     <= !we_q && (rd_q != 5'd0);
              rsp_data_o    <= we_q ? 32'd0 : ld_data;
              rsp_exc_o     <= 2'b00;
              rsp_badaddr_o <= 32'd0;
            end
          end else if (timeout_hit) begin
            rsp_rd_o      <= rd_q;
            rsp_wen_o     <= 1'b0;
            rsp_data_o    <= 32'd0;
            rsp_exc_o     <= 2'b11;
            rsp_badaddr_o <= addr_q;
          end
        end
        default: cnt_q <= 32'd0;
      endcase
    end
  end

endmodule

// File: tb/tb_prirv32_lsu.sv
// tb/tb_prirv32_lsu.sv - directed self-checking bench for prirv32_lsu

module tb_prirv32_lsu;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        lsu_valid_i = 1'b0;
  logic        lsu_ready_o;
  logic        lsu_we_i = 1'b0;
  logic [2:0]  lsu_funct3_i = 3'd0;
  logic [31:0] lsu_addr_i = 32'd0;
  logic [31:0] lsu_wdata_i = 32'd0;
  logic [4:0]  lsu_rd_i = 5'd0;
  logic        mem_req_o;
  logic        mem_we_o;
  logic [31:0] mem_addr_o;
  logic [3:0]  mem_wstrb_o;
  logic [31:0] mem_wdata_o;
  logic        mem_ack_i = 1'b0;
  logic        mem_err_i = 1'b0;
  logic [31:0] mem_rdata_i = 32'd0;
  logic        rsp_valid_o;
  logic        rsp_wen_o;
  logic [4:0]  rsp_rd_o;
  logic [31:0] rsp_data_o;
  logic [1:0]  rsp_exc_o;
  logic [31:0] rsp_badaddr_o;

  int n_checks = 0;
  int n_pass   = 0;
  int req_cycles = 0;
  int vld_pulses = 0;

  prirv32_lsu #(.TIMEOUT_CYCLES(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .lsu_valid_i(lsu_valid_i), .lsu_ready_o(lsu_ready_o),
    .lsu_we_i(lsu_we_i), .lsu_funct3_i(lsu_funct3_i),
    .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i), .lsu_rd_i(lsu_rd_i),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wstrb_o(mem_wstrb_o), .mem_wdata_o(mem_wdata_o),
    .mem_ack_i(mem_ack_i), .mem_err_i(mem_err_i), .mem_rdata_i(mem_rdata_i),
    .rsp_valid_o(rsp_valid_o), .rsp_wen_o(rsp_wen_o), .rsp_rd_o(rsp_rd_o),
    .rsp_data_o(rsp_data_o), .rsp_exc_o(rsp_exc_o), .rsp_badaddr_o(rsp_badaddr_o)
  );

  always #5 clk_i = ~clk_i;

  // Cycles with req / valid high, counted at the edge that closes each cycle.
  always @(posedge clk_i) begin
    if (mem_req_o)   req_cycles++;
    if (rsp_valid_o) vld_pulses++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp)
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    else
      n_pass++;
  endtask

  // Starts and ends just after a falling edge; ends in the cycle after acceptance.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [4:0] rd);
    lsu_valid_i  = 1'b1;
    lsu_we_i     = we;
    lsu_funct3_i = f3;
    lsu_addr_i   = addr;
    lsu_wdata_i  = wd;
    lsu_rd_i     = rd;
    req_cycles   = 0;
    vld_pulses   = 0;
    @(posedge clk_i);
    @(negedge clk_i);
    lsu_valid_i  = 1'b0;
  endtask

  // Holds off the ack for 'waits' BUS cycles, then acks; ends in the RESP cycle.
  task automatic ack_after(input int waits, input logic err, input logic [31:0] rdata);
    repeat (waits) begin
      @(posedge clk_i);
      @(negedge clk_i);
    end
    mem_ack_i   = 1'b1;
    mem_err_i   = err;
    mem_rdata_i = rdata;
    @(posedge clk_i);
    @(negedge clk_i);
    mem_ack_i   = 1'b0;
    mem_err_i   = 1'b0;
    mem_rdata_i = 32'h5A5A5A5A;
  endtask

  task automatic chk_rsp(input string tag, input logic wen, input logic [4:0] rd,
                         input logic [31:0] data, input logic [1:0] exc,
                         input logic [31:0] bad);
    chk({tag, ".valid"}, 32'(rsp_valid_o), 32'd1);
    chk({tag, ".wen"}, 32'(rsp_wen_o), 32'(wen));
    chk({tag, ".rd"}, 32'(rsp_rd_o), 32'(rd));
    chk({tag, ".data"}, rsp_data_o, data);
    chk({tag, ".exc"}, 32'(rsp_exc_o), 32'(exc));
    chk({tag, ".bad"}, rsp_badaddr_o, bad);
  endtask

  // One cycle past RESP: back to idle with exactly one pulse seen.
  task automatic chk_done(input string tag, input int exp_req);
    @(posedge clk_i);
    @(negedge clk_i);
    chk({tag, ".ready"}, 32'(lsu_ready_o), 32'd1);
    chk({tag, ".vld_off"}, 32'(rsp_valid_o), 32'd0);
    chk({tag, ".pulses"}, 32'(vld_pulses), 32'd1);
    chk({tag, ".req_cyc"}, 32'(req_cycles), 32'(exp_req));
  endtask

  initial begin
    repeat (2) @(negedge clk_i);
    chk("rst.req", 32'(mem_req_o), 32'd0);
    chk("rst.valid", 32'(rsp_valid_o), 32'd0);
    chk("rst.wstrb", 32'(mem_wstrb_o), 32'd0);
    chk("rst.data", rsp_data_o, 32'd0);
    chk("rst.exc", 32'(rsp_exc_o), 32'd0);
    rst_i = 1'b0;
    @(negedge clk_i);
    chk("idle.ready", 32'(lsu_ready_o), 32'd1);

    // SW with two wait cycles
    issue(1'b1, 3'b010, 32'h0000_1000, 32'hDEAD_BEEF, 5'd0);
    chk("sw.req", 32'(mem_req_o), 32'd1);
    chk("sw.ready", 32'(lsu_ready_o), 32'd0);
    chk("sw.we", 32'(mem_we_o), 32'd1);
    chk("sw.addr", mem_addr_o, 32'h0000_1000);
    chk("sw.wstrb", 32'(mem_wstrb_o), 32'hF);
    chk("sw.wdata", mem_wdata_o, 32'hDEAD_BEEF);
    ack_after(2, 1'b0, 32'h0);
    chk_rsp("sw", 1'b0, 5'd0, 32'h0, 2'b00, 32'h0);
    chk_done("sw", 3);

    // LB / LBU from the top byte lane, immediate ack
    issue(1'b0, 3'b000, 32'h0000_2003, 32'h0, 5'd5);
    chk("lb.addr", mem_addr_o, 32'h0000_2000);
    chk("lb.wstrb", 32'(mem_wstrb_o), 32'h0);
    chk("lb.we", 32'(mem_we_o), 32'd0);
    ack_after(0, 1'b0, 32'h8011_2233);
    chk_rsp("lb", 1'b1, 5'd5, 32'hFFFF_FF80, 2'b00, 32'h0);
    chk_done("lb", 1);

    issue(1'b0, 3'b100, 32'h0000_2003, 32'h0, 5'd6);
    ack_after(0, 1'b0, 32'h8011_2233);
    chk_rsp("lbu", 1'b1, 5'd6, 32'h0000_0080, 2'b00, 32'h0);
    chk_done("lbu", 1);

    // LH upper half sign-extends, LHU zero-extends
    issue(1'b0, 3'b001, 32'h0000_2002, 32'h0, 5'd9);
    ack_after(0, 1'b0, 32'h8011_2233);
    chk_rsp("lh", 1'b1, 5'd9, 32'hFFFF_8011, 2'b00, 32'h0);
    chk_done("lh", 1);

    issue(1'b0, 3'b101, 32'h0000_2000, 32'h0, 5'd9);
    ack_after(0, 1'b0, 32'h8011_A233);
    chk_rsp("lhu", 1'b1, 5'd9, 32'h0000_A233, 2'b00, 32'h0);
    chk_done("lhu", 1);

    // SH upper half, then misaligned LH
    issue(1'b1, 3'b001, 32'h0000_3002, 32'h0000_ABCD, 5'd0);
    chk("sh.wdata", mem_wdata_o, 32'hABCD_ABCD);
    chk("sh.wstrb", 32'(mem_wstrb_o), 32'hC);
    ack_after(0, 1'b0, 32'h0);
    chk_rsp("sh", 1'b0, 5'd0, 32'h0, 2'b00, 32'h0);
    chk_done("sh", 1);

    issue(1'b1, 3'b000, 32'h0000_3001, 32'h0000_00A7, 5'd0);
    chk("sb.wdata", mem_wdata_o, 32'hA7A7_A7A7);
    chk("sb.wstrb", 32'(mem_wstrb_o), 32'h2);
    ack_after(1, 1'b0, 32'h0);
    chk_rsp("sb", 1'b0, 5'd0, 32'h0, 2'b00, 32'h0);
    chk_done("sb", 2);

    issue(1'b0, 3'b001, 32'h0000_3001, 32'h0, 5'd7);
    chk("lhmis.req", 32'(mem_req_o), 32'd0);
    chk_rsp("lhmis", 1'b0, 5'd7, 32'h0, 2'b01, 32'h0000_3001);
    chk_done("lhmis", 0);

    // Illegal store funct3
    issue(1'b1, 3'b100, 32'h0000_3100, 32'h1, 5'd0);
    chk("ill.req", 32'(mem_req_o), 32'd0);
    chk_rsp("ill", 1'b0, 5'd0, 32'h0, 2'b01, 32'h0000_3100);
    chk_done("ill", 0);

    // Misaligned word
    issue(1'b0, 3'b010, 32'h0000_3102, 32'h0, 5'd4);
    chk_rsp("lwmis", 1'b0, 5'd4, 32'h0, 2'b01, 32'h0000_3102);
    chk_done("lwmis", 0);

    // Bus error
    issue(1'b0, 3'b010, 32'h0000_4008, 32'h0, 5'd8);
    ack_after(1, 1'b1, 32'h1234_5678);
    chk_rsp("err", 1'b0, 5'd8, 32'h0, 2'b10, 32'h0000_4008);
    chk_done("err", 2);

    // Timeout with no ack
    issue(1'b0, 3'b010, 32'h0000_5000, 32'h0, 5'd3);
    for (int i = 0; i < 10; i++) begin
      if (rsp_valid_o) break;
      @(posedge clk_i);
      @(negedge clk_i);
    end
    chk("to.req_off", 32'(mem_req_o), 32'd0);
    chk("to.req_cyc", 32'(req_cycles), 32'd4);
    chk_rsp("to", 1'b0, 5'd3, 32'h0, 2'b11, 32'h0000_5000);
    chk_done("to", 4);

    // Ack on the expiring edge wins
    issue(1'b0, 3'b010, 32'h0000_5004, 32'h0, 5'd3);
    ack_after(3, 1'b0, 32'hCAFE_F00D);
    chk_rsp("toack", 1'b1, 5'd3, 32'hCAFE_F00D, 2'b00, 32'h0);
    chk_done("toack", 4);

    // Load to x0
    issue(1'b0, 3'b010, 32'h0000_6000, 32'h0, 5'd0);
    ack_after(0, 1'b0, 32'h1111_1111);
    chk_rsp("x0", 1'b0, 5'd0, 32'h1111_1111, 2'b00, 32'h0);
    chk_done("x0", 1);

    // Reset in the middle of a bus request
    issue(1'b0, 3'b010, 32'h0000_7000, 32'h0, 5'd2);
    chk("rstmid.req_on", 32'(mem_req_o), 32'd1);
    #2 rst_i = 1'b1;
    #1;
    chk("rstmid.req_off", 32'(mem_req_o), 32'd0);
    chk("rstmid.valid", 32'(rsp_valid_o), 32'd0);
    @(negedge clk_i);
    rst_i = 1'b0;
    repeat (3) @(negedge clk_i);
    chk("rstmid.ready", 32'(lsu_ready_o), 32'd1);
    chk("rstmid.pulses", 32'(vld_pulses), 32'd0);
    chk("rstmid.req_idle", 32'(mem_req_o), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
